cpu_pwr_monitor: RTL

//  CPU-side receiver of the DCLO/ACLO power-status pair of the internal M4 CPU.

---
 rtl/cpu_pwr_monitor_pkg.sv | 32 +++
 rtl/cpu_pwr_monitor_if.sv | 25 ++
 rtl/cpu_pwr_monitor_sync.sv | 24 ++
 rtl/cpu_pwr_monitor.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cpu_pwr_monitor_pkg.sv
// Shared definitions for the M4 CPU power-status monitor.
// Holds the state encodings and the width helper used by the RTL and the bench.
package cpu_pwr_monitor_pkg;

    typedef enum logic [2:0] {
        ST_DCLO   = 3'd0,
        ST_INIT   = 3'd1,
        ST_ACLO   = 3'd2,
        ST_RUN    = 3'd3,
        ST_PFAIL  = 3'd4,
        ST_PFHOLD = 3'd5
    } pwr_state_e;

    localparam int unsigned PF_CNT_W = 8;

    // Bits needed to hold values 0..v-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cpu_pwr_monitor_if.sv
// DCLO/ACLO status inputs, power-fail handshake and sequencing outputs of the monitor.
// master = CPU/board side driving the lines, slave = the monitor.
interface cpu_pwr_if;
    import cpu_pwr_monitor_pkg::*;

    logic                dclo;
    logic                aclo;
    logic                pf_ack;
    logic                init;
    logic                halt;
    logic                restart;
    logic                pf_req;
    logic [PF_CNT_W-1:0] pf_cnt;

    modport master (
        output dclo, aclo, pf_ack,
        input  init, halt, restart, pf_req, pf_cnt
    );

    modport slave (
        input  dclo, aclo, pf_ack,
        output init, halt, restart, pf_req, pf_cnt
    );

endinterface

// File: rtl/cpu_pwr_monitor_sync.sv
// N-stage synchroniser; reset loads every stage with RST_VAL.
module cpu_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_pwr_monitor.sv
// Power-up / power-fail sequencer driven by synchronised DCLO/ACLO.
// Optional `PWR_STATUS_EN builds a saturating power-fail event counter on pf_cnt.
module cpu_pwr_monitor
    import cpu_pwr_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned INIT_CLK    = 8,
    parameter int unsigned PF_TIMEOUT  = 2048
) (
    input  logic     clk_i,
    input  logic     rst_i,
    cpu_pwr_if.slave pwr
);

    localparam int unsigned CNT_W = clog2(max2(INIT_CLK, PF_TIMEOUT));
    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CLK - 1);
    localparam logic [CNT_W-1:0] PF_LOAD   = CNT_W'(PF_TIMEOUT - 1);

    logic dclo_s;
    logic aclo_s;

    pwr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_q, init_d;
    logic             halt_q, halt_d;
    logic             restart_q, restart_d;
    logic             pf_req_q, pf_req_d;

    cpu_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dclo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pwr.dclo),
        .q_o   (dclo_s)
    );

    cpu_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_aclo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pwr.aclo),
        .q_o   (aclo_s)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_DCLO;
            cnt_q     <= '0;
            init_q    <= 1'b1;
            halt_q    <= 1'b1;
            restart_q <= 1'b0;
            pf_req_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            init_q    <= init_d;
            halt_q    <= halt_d;
            restart_q <= restart_d;
            pf_req_q  <= pf_req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (dclo_s) begin
            state_d = ST_DCLO;
        end else begin
            unique case (state_q)
                ST_DCLO: begin
                    state_d = ST_INIT;
                    cnt_d   = INIT_LOAD;
                end
                ST_INIT: begin
                    if (cnt_q == '0) state_d = ST_ACLO;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                ST_ACLO: begin
                    if (!aclo_s) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (aclo_s) state_d = ST_PFAIL;
                end
                ST_PFAIL: begin
                    if (pwr.pf_ack) begin
                        state_d = ST_PFHOLD;
                        cnt_d   = PF_LOAD;
                    end
                end
                ST_PFHOLD: begin
                    // ACLO release beats the timeout when both land on one cycle
                    if (!aclo_s)              state_d = ST_ACLO;
                    else if (cnt_q == '0)     state_d = ST_DCLO;
                    else                      cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = ST_DCLO;
            endcase
        end

        init_d    = (state_d == ST_DCLO) || (state_d == ST_INIT);
        halt_d    = (state_d == ST_DCLO) || (state_d == ST_INIT) || (state_d == ST_ACLO);
        pf_req_d  = (state_d == ST_PFAIL);
        restart_d = (state_q == ST_ACLO) && (state_d == ST_RUN);
    end

    assign pwr.init    = init_q;
    assign pwr.halt    = halt_q;
    assign pwr.restart = restart_q;
    assign pwr.pf_req  = pf_req_q;

`ifdef PWR_STATUS_EN
    logic [PF_CNT_W-1:0] pf_cnt_q, pf_cnt_d;

    always_comb begin
        pf_cnt_d = pf_cnt_q;
        if ((state_q == ST_RUN) && (state_d == ST_PFAIL) && (pf_cnt_q != '1)) begin
            pf_cnt_d = pf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pf_cnt_q <= '0;
        else       pf_cnt_q <= pf_cnt_d;
    end

    assign pwr.pf_cnt = pf_cnt_q;
`else
    assign pwr.pf_cnt = '0;
`endif

endmodule
